// File: rtl/ila_window_capture.sv
// ILA capture engine: records a 2^BUFFER_W-sample window around a trigger event and drains
// it as an AXI-Stream of DATA_W words, low word of each sample first.
module ila_window_capture #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SIGNAL_W  = 64,
  parameter int unsigned BUFFER_W  = 8,
  parameter int unsigned TRIGGER_W = 4
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 cke_i,
  input  logic [SIGNAL_W-1:0]  signal_i,
  input  logic [TRIGGER_W-1:0] trigger_i,
  input  logic [TRIGGER_W-1:0] trigger_mask_i,
  input  logic [TRIGGER_W-1:0] negate_i,
  input  logic                 reduce_and_i,
  input  logic [BUFFER_W-1:0]  pre_count_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  output logic [2:0]           state_o,
  output logic                 done_o,
  output logic [BUFFER_W-1:0]  trig_addr_o,
  output logic [DATA_W-1:0]    m_tdata_o,
  output logic                 m_tvalid_o,
  output logic                 m_tlast_o,
  input  logic                 m_tready_i
);

  localparam int unsigned N_WORDS    = (SIGNAL_W + DATA_W - 1) / DATA_W;
  localparam int unsigned WIDE_W     = N_WORDS * DATA_W;
  localparam int unsigned DEPTH      = 2 ** BUFFER_W;
  localparam int unsigned CNT_W      = BUFFER_W + 1;
  localparam int unsigned WORD_IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(N_WORDS - 1);
  localparam logic [BUFFER_W-1:0]   LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPre   = 3'd1,
    StWait  = 3'd2,
    StPost  = 3'd3,
    StDrain = 3'd4
  } state_e;

  // Input stage: sample and trigger registered together so they stay aligned.
  logic [SIGNAL_W-1:0]  sig1_q;
  logic [TRIGGER_W-1:0] trig1_q;

  state_e               state_q, state_d;
  logic                 done_q, done_d;
  logic [BUFFER_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BUFFER_W-1:0]  fill_q, fill_d;
  logic [BUFFER_W-1:0]  p_q, p_d;
  logic [BUFFER_W-1:0]  trig_addr_q, trig_addr_d;
  logic [BUFFER_W-1:0]  post_left_q, post_left_d;
  logic [BUFFER_W-1:0]  rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_last_q, rd_last_d;
  logic [WORD_IDX_W-1:0] word_idx_q, word_idx_d;
  logic [DATA_W-1:0]    tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;

  logic                 mem_we;
  logic                 rd_en;
  logic                 hit;
  logic                 out_free;
  logic [TRIGGER_W-1:0] trig_t;

  logic [SIGNAL_W-1:0]  mem_q [DEPTH];
  logic [SIGNAL_W-1:0]  rd_data_q;
  logic [WIDE_W-1:0]    rd_wide;
  logic [DATA_W-1:0]    rd_word;

  always_comb begin
    trig_t = trig1_q ^ negate_i;
    if (reduce_and_i) begin
      hit = &(trig_t | ~trigger_mask_i);
    end else begin
      hit = |(trig_t & trigger_mask_i);
    end
  end

  // Zero-extend the sample so the top word carries zeros above SIGNAL_W.
  assign rd_wide = WIDE_W'(rd_data_q);
  assign rd_word = rd_wide[word_idx_q*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    p_d         = p_q;
    trig_addr_d = trig_addr_q;
    post_left_d = post_left_q;
    rd_addr_d   = rd_addr_q;
    rd_cnt_d    = rd_cnt_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    word_idx_d  = word_idx_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
    out_free    = !tvalid_q || m_tready_i;

    if (abort_i) begin
      // Abort drops the stream immediately, even mid-word.
      state_d    = StIdle;
      tvalid_d   = 1'b0;
      tlast_d    = 1'b0;
      rd_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arm_i) begin
            done_d   = 1'b0;
            wr_ptr_d = '0;
            fill_d   = '0;
            p_d      = pre_count_i;
            state_d  = (pre_count_i == '0) ? StWait : StPre;
          end
        end

        StPre: begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          fill_d   = fill_q + 1'b1;
          if (fill_d == p_q) begin
            state_d = StWait;
          end
        end

        StWait: begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (hit) begin
            trig_addr_d = wr_ptr_q;
            post_left_d = LAST_ADDR - p_q;
            rd_addr_d   = wr_ptr_q - p_q;
            rd_cnt_d    = '0;
            rd_valid_d  = 1'b0;
            word_idx_d  = '0;
            state_d     = (p_q == LAST_ADDR) ? StDrain : StPost;
          end
        end

        StPost: begin
          mem_we      = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          post_left_d = post_left_q - 1'b1;
          if (post_left_q == BUFFER_W'(1)) begin
            state_d = StDrain;
          end
        end

        StDrain: begin
          if (tvalid_q && m_tready_i) begin
            tvalid_d = 1'b0;
            if (tlast_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
              tlast_d = 1'b0;
            end
          end
          if (out_free && rd_valid_q) begin
            tdata_d  = rd_word;
            tvalid_d = 1'b1;
            tlast_d  = rd_last_q && (word_idx_q == LAST_WORD);
            if (word_idx_q == LAST_WORD) begin
              word_idx_d = '0;
              rd_valid_d = 1'b0;
            end else begin
              word_idx_d = word_idx_q + 1'b1;
            end
          end
          // Refill the read register as soon as its sample has been fully serialised.
          if (!rd_valid_d && (rd_cnt_q != CNT_FULL)) begin
            rd_en      = 1'b1;
            rd_addr_d  = rd_addr_q + 1'b1;
            rd_cnt_d   = rd_cnt_q + 1'b1;
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_cnt_q == CNT_LAST);
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sig1_q      <= '0;
      trig1_q     <= '0;
      state_q     <= StIdle;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      p_q         <= '0;
      trig_addr_q <= '0;
      post_left_q <= '0;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      word_idx_q  <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else if (cke_i) begin
      sig1_q      <= signal_i;
      trig1_q     <= trigger_i;
      state_q     <= state_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      p_q         <= p_d;
      trig_addr_q <= trig_addr_d;
      post_left_q <= post_left_d;
      rd_addr_q   <= rd_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      word_idx_q  <= word_idx_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  // Sample buffer with a synchronous, enabled read port; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (cke_i && mem_we) begin
      mem_q[wr_ptr_q] <= sig1_q;
    end
    if (cke_i && rd_en) begin
      rd_data_q <= mem_q[rd_addr_q];
    end
  end

  assign state_o     = state_q;
  assign done_o      = done_q;
  assign trig_addr_o = trig_addr_q;
  assign m_tdata_o   = tdata_q;
  assign m_tvalid_o  = tvalid_q;
  assign m_tlast_o   = tlast_q;

endmodule
